// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU bus widths, control strobe indices and bus source type
// Purpose: common constants for blocks on the 8-bit CPU bus.
// Ports: none (package).
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 8;

  // Bit positions of the control unit's c_* strobes when gathered into a vector.
  localparam int C_MEMADDR   = 0;
  localparam int C_DATAREAD  = 1;
  localparam int C_DATAWRITE = 2;
  localparam int C_AUTOINC   = 3;
  localparam int C_PUSH      = 4;
  localparam int C_POP       = 5;
  localparam int C_SPREAD    = 6;
  localparam int C_FLAGCLR   = 7;
  localparam int C_NUM       = 8;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_POP  = 2'd1,
    SRC_MEM  = 2'd2,
    SRC_SP   = 2'd3
  } bus_src_e;

endpackage

// File: rtl/dm_stack_ctrl.sv
// rtl/dm_stack_ctrl.sv - stack pointer, occupancy count, error flags and push/pop accept logic
// Purpose: owns the downward-growing hardware stack state of the data memory.
// Ports: clk_i/reset_i clock and sync active-high reset; push_i/pop_i/flagclr_i requests;
//        sp_o next free slot, top_addr_o current top (SP+1); wr_en_o RAM write for an
//        accepted push; pop_ok_o pop accepted; empty_o/full_o occupancy; ovf_o/udf_o sticky errors.
module dm_stack_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = CPU_ADDR_W,
  parameter int STK_TOP   = 255,
  parameter int STK_DEPTH = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flagclr_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic [ADDR_W-1:0] top_addr_o,
  output logic              wr_en_o,
  output logic              pop_ok_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int CNT_W = $clog2(STK_DEPTH + 1);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_ok, pop_ok, ovf_evt, udf_evt;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(STK_DEPTH));

  // A simultaneous pop swallows the push silently, so only a lone push can overflow.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & ~pop_i & ~full_o;
  assign ovf_evt = push_i & ~pop_i & full_o;
  assign udf_evt = pop_i & empty_o;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (pop_ok) begin
      sp_d  = sp_q + ADDR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push_ok) begin
      sp_d  = sp_q - ADDR_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end
    // An error in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_evt | (ovf_q & ~flagclr_i);
    udf_d = udf_evt | (udf_q & ~flagclr_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sp_q  <= ADDR_W'(STK_TOP);
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign sp_o       = sp_q;
  assign top_addr_o = sp_q + ADDR_W'(1);
  assign wr_en_o    = push_ok & ~reset_i;
  assign pop_ok_o   = pop_ok;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;

endmodule

// File: rtl/datamem_stk.sv
// rtl/datamem_stk.sv - bus-attached data RAM with MAR, post-increment and hardware stack
// Purpose: CPU data memory on the shared bus, driven by the control unit's c_* strobes.
// Ports: clk/reset clock and sync active-high reset; bus_in address or write data;
//        bus_out read data, 'z when not driving; c_* control strobes;
//        stk_empty/stk_full stack occupancy; err_ovf/err_udf sticky stack errors.
module datamem_stk
  import cpu_pkg::*;
#(
  parameter int DATA_W    = CPU_DATA_W,
  parameter int ADDR_W    = CPU_ADDR_W,
  parameter int STK_TOP   = 255,
  parameter int STK_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  input  logic              c_memaddr,
  input  logic              c_dataread,
  input  logic              c_datawrite,
  input  logic              c_autoinc,
  input  logic              c_push,
  input  logic              c_pop,
  input  logic              c_spread,
  input  logic              c_flagclr,
  output logic              stk_empty,
  output logic              stk_full,
  output logic              err_ovf,
  output logic              err_udf
);

  logic [C_NUM-1:0]  ctl;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] sp, top_addr;
  logic              stk_wr, pop_ok;
  logic              push_req, dw_acc, rd_acc;
  bus_src_e          src;
  logic [DATA_W-1:0] drv_data;

  assign ctl = {c_flagclr, c_spread, c_pop, c_push, c_autoinc, c_datawrite, c_dataread, c_memaddr};

  // bus_in carries an address under c_memaddr, so neither push nor datawrite may use it;
  // a push outranks a datawrite for the single RAM write port.
  assign push_req = ctl[C_PUSH] & ~ctl[C_MEMADDR];
  assign dw_acc   = ctl[C_DATAWRITE] & ~ctl[C_MEMADDR] & ~ctl[C_PUSH];
  assign rd_acc   = ctl[C_DATAREAD] & ~ctl[C_POP];

  dm_stack_ctrl #(
    .ADDR_W   (ADDR_W),
    .STK_TOP  (STK_TOP),
    .STK_DEPTH(STK_DEPTH)
  ) u_stack (
    .clk_i     (clk),
    .reset_i   (reset),
    .push_i    (push_req),
    .pop_i     (ctl[C_POP]),
    .flagclr_i (ctl[C_FLAGCLR]),
    .sp_o      (sp),
    .top_addr_o(top_addr),
    .wr_en_o   (stk_wr),
    .pop_ok_o  (pop_ok),
    .empty_o   (stk_empty),
    .full_o    (stk_full),
    .ovf_o     (err_ovf),
    .udf_o     (err_udf)
  );

  always_comb begin
    mar_d = mar_q;
    if (ctl[C_MEMADDR]) begin
      mar_d = bus_in[ADDR_W-1:0];
    end else if (ctl[C_AUTOINC] && (rd_acc || dw_acc)) begin
      mar_d = mar_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar_q <= '0;
    end else begin
      mar_q <= mar_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stk_wr) begin
      mem_q[sp] <= bus_in;
    end else if (dw_acc && !reset) begin
      mem_q[mar_q] <= bus_in;
    end
  end

  always_comb begin
    src = SRC_NONE;
    if (ctl[C_POP]) begin
      src = SRC_POP;
    end else if (ctl[C_DATAREAD]) begin
      src = SRC_MEM;
    end else if (ctl[C_SPREAD]) begin
      src = SRC_SP;
    end
  end

  always_comb begin
    drv_data = '0;
    case (src)
      SRC_POP:  drv_data = pop_ok ? mem_q[top_addr] : '0;
      SRC_MEM:  drv_data = mem_q[mar_q];
      SRC_SP:   drv_data = DATA_W'(sp);
      default:  drv_data = '0;
    endcase
  end

  assign bus_out = (src != SRC_NONE) ? drv_data : 'z;

endmodule

// File: tb/tb_datamem_stk.sv
// tb/tb_datamem_stk.sv - self-checking bench for datamem_stk with a behavioural model
module tb_datamem_stk;

  localparam int TOP   = 255;
  localparam int DEPTH = 32;

  localparam int M  = 1;
  localparam int R  = 2;
  localparam int W  = 4;
  localparam int A  = 8;
  localparam int PU = 16;
  localparam int PO = 32;
  localparam int SR = 64;
  localparam int CL = 128;
  localparam int RS = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  wire  [7:0] bus_out;
  logic       c_memaddr, c_dataread, c_datawrite, c_autoinc;
  logic       c_push, c_pop, c_spread, c_flagclr;
  logic       stk_empty, stk_full, err_ovf, err_udf;

  always #5 clk = ~clk;

  datamem_stk dut (
    .clk        (clk),
    .reset      (reset),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .c_memaddr  (c_memaddr),
    .c_dataread (c_dataread),
    .c_datawrite(c_datawrite),
    .c_autoinc  (c_autoinc),
    .c_push     (c_push),
    .c_pop      (c_pop),
    .c_spread   (c_spread),
    .c_flagclr  (c_flagclr),
    .stk_empty  (stk_empty),
    .stk_full   (stk_full),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf)
  );

  int total = 0;
  int bad   = 0;

  // Model: RAM image with known-bits, MAR, stack occupancy; SP is derived as TOP-count.
  logic [7:0] m_mem [256];
  bit         m_vld [256];
  int         m_mar = 0;
  int         m_cnt = 0;
  bit         m_ovf = 0;
  bit         m_udf = 0;
  logic [7:0] last_bus;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_strobes(input int s, input logic [7:0] d);
    c_memaddr   = s[0];
    c_dataread  = s[1];
    c_datawrite = s[2];
    c_autoinc   = s[3];
    c_push      = s[4];
    c_pop       = s[5];
    c_spread    = s[6];
    c_flagclr   = s[7];
    reset       = s[8];
    bus_in      = d;
  endtask

  task automatic cyc(input int s, input logic [7:0] d);
    bit drv, known;
    int val, a;
    bit push_eff, dw, rd_acc, ovf_e, udf_e;
    @(negedge clk);
    set_strobes(s, d);
    #2;
    last_bus = bus_out;
    drv = 1'b1; known = 1'b1; val = 0;
    if (s[5]) begin
      if (m_cnt > 0) begin
        a = TOP - m_cnt + 1;
        known = m_vld[a];
        val = m_mem[a];
      end
    end else if (s[1]) begin
      known = m_vld[m_mar];
      val = m_mem[m_mar];
    end else if (s[6]) begin
      val = TOP - m_cnt;
    end else begin
      drv = 1'b0;
    end
    if (drv && known) begin
      chk("bus_out", int'(bus_out), val);
    end else if (!drv) begin
      total++;
      if (!(bus_out === 8'hzz || bus_out === 8'h00)) begin
        bad++;
        $display("FAIL bus_undriven actual=%0h required=zz @%0t", bus_out, $time);
      end
    end
    chk("stk_empty", int'(stk_empty), int'(m_cnt == 0));
    chk("stk_full", int'(stk_full), int'(m_cnt == DEPTH));
    chk("err_ovf", int'(err_ovf), int'(m_ovf));
    chk("err_udf", int'(err_udf), int'(m_udf));

    if (s[8]) begin
      m_mar = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
    end else begin
      push_eff = s[4] && !s[0];
      dw       = s[2] && !s[0] && !s[4];
      rd_acc   = s[1] && !s[5];
      ovf_e    = 0;
      udf_e    = 0;
      if (s[5]) begin
        if (m_cnt > 0) m_cnt--;
        else udf_e = 1;
      end else if (push_eff) begin
        if (m_cnt < DEPTH) begin
          m_mem[TOP - m_cnt] = d;
          m_vld[TOP - m_cnt] = 1;
          m_cnt++;
        end else begin
          ovf_e = 1;
        end
      end
      if (dw) begin
        m_mem[m_mar] = d;
        m_vld[m_mar] = 1;
      end
      m_ovf = ovf_e || (m_ovf && !s[7]);
      m_udf = udf_e || (m_udf && !s[7]);
      if (s[0]) m_mar = int'(d);
      else if (s[3] && (rd_acc || dw)) m_mar = (m_mar + 1) % 256;
    end
    @(posedge clk);
    #1;
    set_strobes(0, d);
  endtask

  initial begin
    int s;
    set_strobes(RS, 8'h00);

    // Reset state
    cyc(RS, 8'h00);
    cyc(RS, 8'h00);
    chk("rst_empty", int'(stk_empty), 1);
    chk("rst_full", int'(stk_full), 0);
    chk("rst_ovf", int'(err_ovf), 0);
    chk("rst_udf", int'(err_udf), 0);
    cyc(SR, 8'h00);
    chk("rst_sp", int'(last_bus), 255);

    // 1: write/read with autoinc
    cyc(M, 8'h10);
    cyc(W | A, 8'hA5);
    cyc(W | A, 8'h5A);
    cyc(M, 8'h10);
    cyc(R | A, 8'h00);
    chk("t1_rd0", int'(last_bus), 8'hA5);
    cyc(R | A, 8'h00);
    chk("t1_rd1", int'(last_bus), 8'h5A);
    cyc(W, 8'h33);
    cyc(M, 8'h12);
    cyc(R, 8'h00);
    chk("t1_mar12", int'(last_bus), 8'h33);

    // 2: MAR wrap
    cyc(M, 8'hFF);
    cyc(W | A, 8'h77);
    cyc(W, 8'h66);
    cyc(M, 8'hFF);
    cyc(R, 8'h00);
    chk("t2_ff", int'(last_bus), 8'h77);
    cyc(M, 8'h00);
    cyc(R, 8'h00);
    chk("t2_wrap", int'(last_bus), 8'h66);

    // 3: stack order
    cyc(PU, 8'd1);
    cyc(PU, 8'd2);
    cyc(PU, 8'd3);
    cyc(SR, 8'h00);
    chk("t3_sp", int'(last_bus), 252);
    cyc(PO, 8'h00);
    chk("t3_pop3", int'(last_bus), 3);
    cyc(PO, 8'h00);
    chk("t3_pop2", int'(last_bus), 2);
    cyc(PO, 8'h00);
    chk("t3_pop1", int'(last_bus), 1);
    chk("t3_empty", int'(stk_empty), 1);
    cyc(SR, 8'h00);
    chk("t3_sp255", int'(last_bus), 255);

    // 4: overflow
    cyc(M, 8'd223);
    cyc(W, 8'hC3);
    for (int i = 0; i < 32; i++) cyc(PU, 8'(8'h80 + i));
    chk("t4_full", int'(stk_full), 1);
    cyc(PU, 8'hEE);
    chk("t4_ovf", int'(err_ovf), 1);
    cyc(SR, 8'h00);
    chk("t4_sp", int'(last_bus), 223);
    cyc(M, 8'd223);
    cyc(R, 8'h00);
    chk("t4_mem223", int'(last_bus), 8'hC3);
    cyc(CL, 8'h00);
    chk("t4_clr", int'(err_ovf), 0);
    for (int i = 0; i < 32; i++) cyc(PO, 8'h00);
    chk("t4_drained", int'(stk_empty), 1);

    // 5: underflow and push+pop
    cyc(PO, 8'h00);
    chk("t5_pop_empty", int'(last_bus), 0);
    chk("t5_udf", int'(err_udf), 1);
    cyc(CL, 8'h00);
    chk("t5_clr", int'(err_udf), 0);
    cyc(PU, 8'h11);
    cyc(PU | PO, 8'h44);
    chk("t5_pushpop_bus", int'(last_bus), 8'h11);
    chk("t5_pushpop_empty", int'(stk_empty), 1);
    chk("t5_pushpop_ovf", int'(err_ovf), 0);

    // 6: reset mid-op
    cyc(PU, 8'hAB);
    cyc(M, 8'd254);
    cyc(W, 8'h5C);
    cyc(RS | PU, 8'h99);
    cyc(SR, 8'h00);
    chk("t6_sp", int'(last_bus), 255);
    chk("t6_empty", int'(stk_empty), 1);
    cyc(M, 8'd254);
    cyc(R, 8'h00);
    chk("t6_nowrite", int'(last_bus), 8'h5C);
    cyc(RS, 8'h00);
    cyc(0, 8'h00);

    // Randomized traffic, alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 3000; i++) begin
      bit push_heavy;
      push_heavy = ((i / 250) % 2) == 0;
      s = 0;
      if ($urandom_range(7) == 0) s |= M;
      if ($urandom_range(3) == 0) s |= R;
      if ($urandom_range(3) == 0) s |= W;
      if ($urandom_range(1) == 0) s |= A;
      if ($urandom_range(push_heavy ? 1 : 4) == 0) s |= PU;
      if ($urandom_range(push_heavy ? 5 : 1) == 0) s |= PO;
      if ($urandom_range(5) == 0) s |= SR;
      if ($urandom_range(9) == 0) s |= CL;
      if ($urandom_range(149) == 0) s |= RS;
      cyc(s, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
